amm_word_reader: RTL

Avalon-MM read master that fetches a byte-addressed, byte-length region from memory and emits it as a valid/ready word stream with per-word byte masks. It sits directly upstream of the byte-increment core: it feeds the core words and tells it which bytes belong to the job. Pipelined reads are throttled by a credit counter, so returned data never overruns the internal buffer.

---
 rtl/amm_pkg.sv | 35 +++
 rtl/amm_rd_fifo.sv | 63 ++++++
 rtl/amm_word_reader.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/amm_pkg.sv
// Shared constants, byte-mask helpers and FSM encoding for the Avalon-MM word reader.
// No logic of its own; everything here is pure combinational helpers.
// Mask helpers return MASK_W bits so one function serves any bus up to 1024 bits.
package amm_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int MASK_W         = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Bytes at or above the starting offset belong to the job.
    function automatic logic [MASK_W-1:0] first_mask(input int offset);
        logic [MASK_W-1:0] m;
        for (int i = 0; i < MASK_W; i++) begin
            m[i] = (i >= offset);
        end
        return m;
    endfunction

    // Bytes at or below the final offset belong to the job.
    function automatic logic [MASK_W-1:0] last_mask(input int offset);
        logic [MASK_W-1:0] m;
        for (int i = 0; i < MASK_W; i++) begin
            m[i] = (i <= offset);
        end
        return m;
    endfunction

endpackage

// File: rtl/amm_rd_fifo.sv
// Synchronous show-ahead FIFO: head entry visible on rd_dat whenever rd_vld.
// Latency: a write at edge t is readable from cycle t+1.
// Backpressure: wr_rdy low when full, entries hold until rd_rdy.
module amm_rd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_vld,
    input  logic [WIDTH-1:0]           wr_dat,
    output logic                       wr_rdy,
    output logic                       rd_vld,
    output logic [WIDTH-1:0]           rd_dat,
    input  logic                       rd_rdy,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             wr_fire, rd_fire;

    assign wr_rdy  = (cnt_q != CW'(DEPTH));
    assign rd_vld  = (cnt_q != '0);
    assign rd_dat  = mem_q[rd_ptr_q];
    assign count   = cnt_q;
    assign wr_fire = wr_vld && wr_rdy;
    assign rd_fire = rd_vld && rd_rdy;

    always_comb begin
        mem_d = mem_q;
        if (wr_fire) begin
            mem_d[wr_ptr_q] = wr_dat;
        end
        // DEPTH is a power of two, so pointers wrap naturally.
        wr_ptr_d = wr_ptr_q + PW'(wr_fire);
        rd_ptr_d = rd_ptr_q + PW'(rd_fire);
        cnt_d    = cnt_q + CW'(wr_fire) - CW'(rd_fire);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/amm_word_reader.sv
// Avalon-MM read master streaming a byte region out as masked words.
// Latency: first read the cycle after start; datavalid at t gives out_valid at t+1.
// Backpressure: credit-limited reads, so out_ready low stalls issue after FIFO_DEPTH words.
module amm_word_reader
    import amm_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int BYTE_CNT    = DATA_WIDTH / 8,
    parameter int BYTE_ADDR_W = ADDR_WIDTH + $clog2(BYTE_CNT),
    parameter int LEN_W       = BYTE_ADDR_W + 1,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [BYTE_ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]       length,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_WIDTH-1:0]  amm_address,
    output logic                   amm_read,
    input  logic                   amm_waitrequest,
    input  logic [DATA_WIDTH-1:0]  amm_readdata,
    input  logic                   amm_datavalid,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [BYTE_CNT-1:0]    out_byteen,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int OFF_W = $clog2(BYTE_CNT);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [BYTE_CNT-1:0]   byteen;
        logic                  last;
    } rsp_t;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   amm_read_q, amm_read_d;
    logic                   done_q, done_d;
    logic [CW-1:0]          credits_q, credits_d;
    logic [CW-1:0]          outst_q, outst_d;
    logic [LEN_W-1:0]       req_left_q, req_left_d;
    logic [LEN_W-1:0]       rsp_idx_q, rsp_idx_d;
    logic [LEN_W-1:0]       n_words_q, n_words_d;
    logic [OFF_W-1:0]       first_off_q, first_off_d;
    logic [OFF_W-1:0]       last_off_q, last_off_d;

    logic                   req_acc, out_hs, rsp_push;
    logic [OFF_W-1:0]       start_off, start_last_off;
    logic [LEN_W:0]         start_span;
    logic [LEN_W-1:0]       start_n, start_end;
    logic [ADDR_WIDTH-1:0]  start_word;
    logic [BYTE_CNT-1:0]    rsp_byteen;
    logic                   rsp_last;
    rsp_t                   push_ent, pop_ent;
    logic                   fifo_wr_rdy, fifo_rd_vld;
    logic [CW-1:0]          fifo_count;

    assign req_acc  = amm_read_q && !amm_waitrequest;
    assign out_hs   = fifo_rd_vld && out_ready;
    // Responses with nothing outstanding (e.g. left over from before a reset) are dropped.
    assign rsp_push = amm_datavalid && (outst_q != '0);

    assign start_off      = base_addr[OFF_W-1:0];
    assign start_word     = base_addr[BYTE_ADDR_W-1:OFF_W];
    assign start_span     = (LEN_W+1)'(start_off) + (LEN_W+1)'(length) + (LEN_W+1)'(BYTE_CNT - 1);
    assign start_n        = LEN_W'(start_span >> OFF_W);
    assign start_end      = LEN_W'(start_off) + length - LEN_W'(1);
    assign start_last_off = start_end[OFF_W-1:0];

    // Masks follow the response count so they line up with returning data, not requests.
    always_comb begin
        rsp_last   = (rsp_idx_q == n_words_q - LEN_W'(1));
        rsp_byteen = '1;
        if (rsp_idx_q == '0) begin
            rsp_byteen &= BYTE_CNT'(first_mask(int'(first_off_q)));
        end
        if (rsp_last) begin
            rsp_byteen &= BYTE_CNT'(last_mask(int'(last_off_q)));
        end
        push_ent.data   = amm_readdata;
        push_ent.byteen = rsp_byteen;
        push_ent.last   = rsp_last;
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        amm_read_d  = amm_read_q;
        done_d      = 1'b0;
        credits_d   = credits_q - CW'(req_acc) + CW'(out_hs);
        outst_d     = outst_q + CW'(req_acc) - CW'(rsp_push);
        req_left_d  = req_left_q;
        rsp_idx_d   = rsp_idx_q;
        n_words_d   = n_words_q;
        first_off_d = first_off_q;
        last_off_d  = last_off_q;

        if (req_acc) begin
            addr_d     = addr_q + ADDR_WIDTH'(1);
            req_left_d = req_left_q - LEN_W'(1);
        end
        if (rsp_push) begin
            rsp_idx_d = rsp_idx_q + LEN_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                amm_read_d = 1'b0;
                if (start) begin
                    if (length != '0) begin
                        state_d     = ST_ISSUE;
                        addr_d      = start_word;
                        amm_read_d  = 1'b1;
                        req_left_d  = start_n;
                        n_words_d   = start_n;
                        rsp_idx_d   = '0;
                        first_off_d = start_off;
                        last_off_d  = start_last_off;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                amm_read_d = (req_left_d != '0) && (credits_d != '0);
                if (req_left_d == '0) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                amm_read_d = 1'b0;
                if (out_hs && pop_ent.last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                amm_read_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            amm_read_q  <= 1'b0;
            done_q      <= 1'b0;
            credits_q   <= CW'(FIFO_DEPTH);
            outst_q     <= '0;
            req_left_q  <= '0;
            rsp_idx_q   <= '0;
            n_words_q   <= '0;
            first_off_q <= '0;
            last_off_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            amm_read_q  <= amm_read_d;
            done_q      <= done_d;
            credits_q   <= credits_d;
            outst_q     <= outst_d;
            req_left_q  <= req_left_d;
            rsp_idx_q   <= rsp_idx_d;
            n_words_q   <= n_words_d;
            first_off_q <= first_off_d;
            last_off_q  <= last_off_d;
        end
    end

    amm_rd_fifo #(
        .WIDTH ($bits(rsp_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (rsp_push),
        .wr_dat (push_ent),
        .wr_rdy (fifo_wr_rdy),
        .rd_vld (fifo_rd_vld),
        .rd_dat (pop_ent),
        .rd_rdy (out_ready),
        .count  (fifo_count)
    );

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign amm_address = addr_q;
    assign amm_read    = amm_read_q;
    assign out_valid   = fifo_rd_vld;
    assign out_data    = pop_ent.data;
    assign out_byteen  = pop_ent.byteen;
    assign out_last    = pop_ent.last;

    a_credit_balance: assert property (@(posedge clk) disable iff (rst)
        int'(credits_q) + int'(outst_q) + int'(fifo_count) == FIFO_DEPTH);
    a_no_overrun: assert property (@(posedge clk) disable iff (rst)
        rsp_push |-> fifo_wr_rdy);

endmodule
